// File: rtl/ntt_butterfly_array.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_butterfly_array
//  Purpose  : LANES parallel radix-2 butterflies over the Goldilocks field
//             p = 2^64 - 2^32 + 1, with valid/ready handshake and global stall.
//             Per-transaction mode: 0 = Cooley-Tukey, 1 = Gentleman-Sande,
//             2/3 = bypass. Twiddle and tag travel alongside the data.
//  Ports    : clk_i, rst_ni (async, active-low)
//             valid_i / ready_o / mode_i / tag_i / x_i / w_i   - input side
//             valid_o / ready_i / x_o / w_o / tag_o            - output side
//             cnt_o  - number of output handshakes since reset (wrapping)
//             x_i/x_o: lane k at [128k+127:128k], {y,x} with x in low half.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_butterfly_array #(
    parameter int LANES     = 4,
    parameter int PD        = 6,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 16,
    parameter bit CANONICAL = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [1:0]             mode_i,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic [LANES*2*64-1:0]  x_i,
    input  logic [LANES*64-1:0]    w_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [LANES*2*64-1:0]  x_o,
    output logic [LANES*64-1:0]    w_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic [CNT_W-1:0]       cnt_o
);

    localparam int          C_XW      = LANES * 128;
    localparam int          C_WW      = LANES * 64;
    // Two arithmetic stages; the remaining PD-2 stages form the result tail.
    localparam int          C_TAIL    = PD - 2;
    localparam logic [63:0] C_P       = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] C_EPS     = 64'h0000_0000_FFFF_FFFF;
    localparam logic [1:0]  C_MODE_CT = 2'd0;
    localparam logic [1:0]  C_MODE_GS = 2'd1;

    // Any 64-bit value is below 2p, so one conditional subtract canonicalises.
    function automatic logic [63:0] f_canon(input logic [63:0] v);
        return (v >= C_P) ? (v - C_P) : v;
    endfunction

    // Operands must be canonical.
    function automatic logic [63:0] f_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, C_P}) begin
            s = s - {1'b0, C_P};
        end
        return s[63:0];
    endfunction

    // Operands must be canonical; the 64-bit wrap makes a-b+p exact when a<b.
    function automatic logic [63:0] f_sub(input logic [63:0] a, input logic [63:0] b);
        return (a >= b) ? (a - b) : (a - b + C_P);
    endfunction

    // z = hh*2^96 + hl*2^64 + lo  ==  lo - hh + hl*(2^32-1)  (mod p).
    // Result lies in [0, 2^64) and is congruent to z; not necessarily < p.
    function automatic logic [63:0] f_reduce(input logic [127:0] z);
        logic [63:0] lo;
        logic [63:0] hh;
        logic [63:0] hl;
        logic [63:0] t0;
        logic [63:0] t1;
        logic [63:0] t2;
        logic [64:0] s;
        lo = z[63:0];
        hl = {32'd0, z[95:64]};
        hh = {32'd0, z[127:96]};
        t0 = lo - hh;
        // Borrow wrapped by 2^64; removing EPS leaves a net +p.
        if (lo < hh) begin
            t0 = t0 - C_EPS;
        end
        t1 = hl * C_EPS;
        s  = {1'b0, t0} + {1'b0, t1};
        t2 = s[63:0];
        // Carry lost 2^64; adding EPS leaves a net -p.
        if (s[64]) begin
            t2 = t2 + C_EPS;
        end
        return t2;
    endfunction

    logic                 w_ce;
    logic [PD-1:0]        r_v;

    logic [C_WW-1:0]      r_s1_a;
    logic [C_WW-1:0]      r_s1_m;
    logic [C_WW-1:0]      r_s1_w;
    logic [1:0]           r_s1_mode;
    logic [TAG_W-1:0]     r_s1_tag;

    logic [C_XW-1:0]      r_s2_prod;
    logic [C_WW-1:0]      r_s2_a;
    logic [C_WW-1:0]      r_s2_m;
    logic [C_WW-1:0]      r_s2_w;
    logic [1:0]           r_s2_mode;
    logic [TAG_W-1:0]     r_s2_tag;

    logic [C_XW-1:0]      r_tx   [C_TAIL];
    logic [C_WW-1:0]      r_tw   [C_TAIL];
    logic [TAG_W-1:0]     r_ttag [C_TAIL];

    logic [CNT_W-1:0]     r_cnt;

    logic [C_WW-1:0]      w_s1_a;
    logic [C_WW-1:0]      w_s1_m;
    logic [C_XW-1:0]      w_prod;
    logic [C_XW-1:0]      w_fx;

    // Stall is global: the pipe advances unless a valid result is blocked.
    assign w_ce    = ready_i | ~r_v[PD-1];
    assign ready_o = w_ce;
    assign valid_o = r_v[PD-1];
    assign x_o     = r_tx[C_TAIL-1];
    assign w_o     = r_tw[C_TAIL-1];
    assign tag_o   = r_ttag[C_TAIL-1];
    assign cnt_o   = r_cnt;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [63:0] w_x;
        logic [63:0] w_y;
        logic [63:0] w_xc;
        logic [63:0] w_yc;
        logic [63:0] w_a;
        logic [63:0] w_m;
        logic [63:0] w_r_raw;
        logic [63:0] w_r;
        logic [63:0] w_ox;
        logic [63:0] w_oy;

        assign w_x  = x_i[128*k +: 64];
        assign w_y  = x_i[128*k+64 +: 64];
        assign w_xc = f_canon(w_x);
        assign w_yc = f_canon(w_y);

        // Stage 1: the multiplier operand is y for CT and (x-y) for GS.
        // The GS sum is formed here so stage 2 only has to multiply.
        always_comb begin
            w_a = w_xc;
            w_m = w_yc;
            if (mode_i == C_MODE_GS) begin
                w_a = f_add(w_xc, w_yc);
                w_m = f_sub(w_xc, w_yc);
            end else if (mode_i != C_MODE_CT) begin
                w_a = CANONICAL ? w_xc : w_x;
                w_m = CANONICAL ? w_yc : w_y;
            end
        end

        assign w_s1_a[64*k +: 64] = w_a;
        assign w_s1_m[64*k +: 64] = w_m;

        // Raw twiddle feeds the multiplier: the reduction accepts any product.
        assign w_prod[128*k +: 128] = {64'd0, r_s1_m[64*k +: 64]} * {64'd0, r_s1_w[64*k +: 64]};

        assign w_r_raw = f_reduce(r_s2_prod[128*k +: 128]);
        assign w_r     = f_canon(w_r_raw);

        // CT post add/sub needs canonical operands, so it always uses w_r.
        always_comb begin
            w_ox = r_s2_a[64*k +: 64];
            w_oy = r_s2_m[64*k +: 64];
            if (r_s2_mode == C_MODE_CT) begin
                w_ox = f_add(r_s2_a[64*k +: 64], w_r);
                w_oy = f_sub(r_s2_a[64*k +: 64], w_r);
            end else if (r_s2_mode == C_MODE_GS) begin
                w_oy = CANONICAL ? w_r : w_r_raw;
            end
        end

        assign w_fx[128*k +: 128] = {w_oy, w_ox};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v       <= '0;
            r_s1_a    <= '0;
            r_s1_m    <= '0;
            r_s1_w    <= '0;
            r_s1_mode <= '0;
            r_s1_tag  <= '0;
            r_s2_prod <= '0;
            r_s2_a    <= '0;
            r_s2_m    <= '0;
            r_s2_w    <= '0;
            r_s2_mode <= '0;
            r_s2_tag  <= '0;
            for (int t = 0; t < C_TAIL; t++) begin
                r_tx[t]   <= '0;
                r_tw[t]   <= '0;
                r_ttag[t] <= '0;
            end
        end else if (w_ce) begin
            // ready_o equals w_ce, so valid_i here is the input handshake.
            r_v       <= {r_v[PD-2:0], valid_i};
            r_s1_a    <= w_s1_a;
            r_s1_m    <= w_s1_m;
            r_s1_w    <= w_i;
            r_s1_mode <= mode_i;
            r_s1_tag  <= tag_i;
            r_s2_prod <= w_prod;
            r_s2_a    <= r_s1_a;
            r_s2_m    <= r_s1_m;
            r_s2_w    <= r_s1_w;
            r_s2_mode <= r_s1_mode;
            r_s2_tag  <= r_s1_tag;
            r_tx[0]   <= w_fx;
            r_tw[0]   <= r_s2_w;
            r_ttag[0] <= r_s2_tag;
            for (int t = 1; t < C_TAIL; t++) begin
                r_tx[t]   <= r_tx[t-1];
                r_tw[t]   <= r_tw[t-1];
                r_ttag[t] <= r_ttag[t-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_v[PD-1] && ready_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_butterfly_array
//  Purpose  : Directed and streaming checks of ntt_butterfly_array against
//             hand-computed values and a mod-p reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_butterfly_array;

    localparam int          LANES = 4;
    localparam int          PD    = 6;
    localparam int          TAG_W = 8;
    localparam int          CNT_W = 16;
    localparam int          XW    = LANES * 128;
    localparam int          WW    = LANES * 64;
    localparam logic [63:0] P     = 64'hFFFF_FFFF_0000_0001;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [1:0]        mode_i = 2'd0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic [XW-1:0]     x_i = '0;
    logic [WW-1:0]     w_i = '0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [XW-1:0]     x_o;
    logic [WW-1:0]     w_o;
    logic [TAG_W-1:0]  tag_o;
    logic [CNT_W-1:0]  cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [XW-1:0]    q_x [$];
    logic [WW-1:0]    q_w [$];
    logic [TAG_W-1:0] q_t [$];

    ntt_butterfly_array #(
        .LANES     (LANES),
        .PD        (PD),
        .TAG_W     (TAG_W),
        .CNT_W     (CNT_W),
        .CANONICAL (1'b1)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .tag_i   (tag_i),
        .x_i     (x_i),
        .w_i     (w_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .x_o     (x_o),
        .w_o     (w_o),
        .tag_o   (tag_o),
        .cnt_o   (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference butterfly using plain 128-bit modular arithmetic.
    function automatic logic [127:0] model_bf(input logic [1:0] mode, input logic [63:0] x,
                                              input logic [63:0] y, input logic [63:0] w);
        logic [127:0] pp, xc, yc, wc, t, xr, yr;
        pp = {64'd0, P};
        xc = {64'd0, x} % pp;
        yc = {64'd0, y} % pp;
        wc = {64'd0, w} % pp;
        case (mode)
            2'd0: begin
                t  = (yc * wc) % pp;
                xr = (xc + t) % pp;
                yr = (xc + pp - t) % pp;
            end
            2'd1: begin
                xr = (xc + yc) % pp;
                t  = (xc + pp - yc) % pp;
                yr = (t * wc) % pp;
            end
            default: begin
                xr = xc;
                yr = yc;
            end
        endcase
        return {yr[63:0], xr[63:0]};
    endfunction

    function automatic logic [XW-1:0] model_all();
        logic [XW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[128*k +: 128] = model_bf(mode_i, x_i[128*k +: 64], x_i[128*k+64 +: 64], w_i[64*k +: 64]);
        end
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return r;
            1: return P - 64'd2 + 64'($urandom_range(0, 4));
            2: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 7));
            default: return 64'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic drive_random();
        mode_i = 2'($urandom_range(0, 3));
        tag_i  = TAG_W'($urandom);
        for (int k = 0; k < LANES; k++) begin
            x_i[128*k +: 64]    = rand64();
            x_i[128*k+64 +: 64] = rand64();
            w_i[64*k +: 64]     = rand64();
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // Sends one transaction (same values on all lanes) with ready_i=1 and
    // returns the cycle count to valid_o plus the output words.
    task automatic send_one(input logic [1:0] mode, input logic [63:0] x, input logic [63:0] y,
                            input logic [63:0] w, input logic [TAG_W-1:0] tag, output int lat,
                            output logic [XW-1:0] xo, output logic [WW-1:0] wo,
                            output logic [TAG_W-1:0] tago);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        mode_i  = mode;
        tag_i   = tag;
        for (int k = 0; k < LANES; k++) begin
            x_i[128*k +: 64]    = x;
            x_i[128*k+64 +: 64] = y;
            w_i[64*k +: 64]     = w;
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < PD + 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        xo   = x_o;
        wo   = w_o;
        tago = tag_o;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", valid_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", ready_o); else n_pass++;
        n_checks++; if (cnt_o !== '0) $display("FAIL reset_cnt: got %0d, expected 0", cnt_o); else n_pass++;
        n_checks++; if (x_o !== '0) $display("FAIL reset_x: got %h, expected 0", x_o); else n_pass++;
        n_checks++; if (w_o !== '0) $display("FAIL reset_w: got %h, expected 0", w_o); else n_pass++;
        n_checks++; if (tag_o !== '0) $display("FAIL reset_tag: got %h, expected 0", tag_o); else n_pass++;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL post_reset_ready: got %b, expected 1", ready_o); else n_pass++;
    endtask

    task automatic test_ct();
        int lat; logic [XW-1:0] xo; logic [WW-1:0] wo; logic [TAG_W-1:0] to;
        send_one(2'd0, 64'd1, 64'd2, 64'd3, 8'hA5, lat, xo, wo, to);
        n_checks++; if (lat != PD) $display("FAIL ct_latency: got %0d, expected %0d", lat, PD); else n_pass++;
        for (int k = 0; k < LANES; k++) begin
            n_checks++; if (xo[128*k +: 64] !== 64'd7) $display("FAIL ct_x lane%0d: got %h, expected 7", k, xo[128*k +: 64]); else n_pass++;
            n_checks++; if (xo[128*k+64 +: 64] !== 64'hFFFF_FFFE_FFFF_FFFC) $display("FAIL ct_y lane%0d: got %h, expected fffffffefffffffc", k, xo[128*k+64 +: 64]); else n_pass++;
            n_checks++; if (wo[64*k +: 64] !== 64'd3) $display("FAIL ct_w lane%0d: got %h, expected 3", k, wo[64*k +: 64]); else n_pass++;
        end
        n_checks++; if (to !== 8'hA5) $display("FAIL ct_tag: got %h, expected a5", to); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== 16'd1) $display("FAIL ct_cnt: got %0d, expected 1", cnt_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL ct_valid_drop: got %b, expected 0", valid_o); else n_pass++;
    endtask

    task automatic test_gs();
        int lat; logic [XW-1:0] xo; logic [WW-1:0] wo; logic [TAG_W-1:0] to;
        send_one(2'd1, 64'd1, 64'd2, 64'd3, 8'h3C, lat, xo, wo, to);
        n_checks++; if (lat != PD) $display("FAIL gs_latency: got %0d, expected %0d", lat, PD); else n_pass++;
        for (int k = 0; k < LANES; k++) begin
            n_checks++; if (xo[128*k +: 64] !== 64'd3) $display("FAIL gs_x lane%0d: got %h, expected 3", k, xo[128*k +: 64]); else n_pass++;
            n_checks++; if (xo[128*k+64 +: 64] !== 64'hFFFF_FFFE_FFFF_FFFE) $display("FAIL gs_y lane%0d: got %h, expected fffffffefffffffe", k, xo[128*k+64 +: 64]); else n_pass++;
        end
        n_checks++; if (to !== 8'h3C) $display("FAIL gs_tag: got %h, expected 3c", to); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== 16'd2) $display("FAIL gs_cnt: got %0d, expected 2", cnt_o); else n_pass++;
    endtask

    task automatic test_wrap();
        int lat; logic [XW-1:0] xo; logic [WW-1:0] wo; logic [TAG_W-1:0] to;
        send_one(2'd0, P - 64'd1, 64'd1, 64'd1, 8'h11, lat, xo, wo, to);
        n_checks++; if (xo[63:0] !== 64'd0) $display("FAIL wrap_ct_x: got %h, expected 0", xo[63:0]); else n_pass++;
        n_checks++; if (xo[127:64] !== 64'hFFFF_FFFE_FFFF_FFFF) $display("FAIL wrap_ct_y: got %h, expected fffffffeffffffff", xo[127:64]); else n_pass++;
        // Bypass: all-ones reduces to 2^32-2, y=p reduces to 0, w passes raw.
        send_one(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, P, 64'hFFFF_FFFF_FFFF_FFFF, 8'h22, lat, xo, wo, to);
        n_checks++; if (lat != PD) $display("FAIL byp_latency: got %0d, expected %0d", lat, PD); else n_pass++;
        n_checks++; if (xo[63:0] !== 64'h0000_0000_FFFF_FFFE) $display("FAIL byp_x: got %h, expected 00000000fffffffe", xo[63:0]); else n_pass++;
        n_checks++; if (xo[127:64] !== 64'd0) $display("FAIL byp_y: got %h, expected 0", xo[127:64]); else n_pass++;
        n_checks++; if (wo[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL byp_w: got %h, expected ffffffffffffffff", wo[63:0]); else n_pass++;
        // Reserved mode 3 behaves as bypass.
        send_one(2'd3, P + 64'd5, 64'd3, 64'd9, 8'h33, lat, xo, wo, to);
        n_checks++; if (xo[63:0] !== 64'd5) $display("FAIL mode3_x: got %h, expected 5", xo[63:0]); else n_pass++;
        n_checks++; if (xo[127:64] !== 64'd3) $display("FAIL mode3_y: got %h, expected 3", xo[127:64]); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== 16'd5) $display("FAIL wrap_cnt: got %0d, expected 5", cnt_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int sent, got, first_in, last_out;
        logic [XW-1:0] ex;
        do_reset();
        q_x.delete(); q_w.delete(); q_t.delete();
        sent = 0; got = 0; first_in = -1; last_out = -1;
        for (int cyc = 0; cyc < 100 + PD + 20 && got < 100; cyc++) begin
            @(posedge clk_i); #1;
            ready_i = 1'b1;
            if (sent < 100) begin
                valid_i = 1'b1;
                drive_random();
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (valid_i && ready_o) begin
                ex = model_all();
                q_x.push_back(ex); q_w.push_back(w_i); q_t.push_back(tag_i);
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (valid_o && ready_i) begin
                got++;
                last_out = cyc;
                n_checks++;
                if (q_x.size() == 0) begin
                    $display("FAIL b2b_unexpected: got an output, expected none pending");
                end else begin
                    n_pass++;
                    n_checks++; if (x_o !== q_x[0]) $display("FAIL b2b_x #%0d: got %h, expected %h", got, x_o, q_x[0]); else n_pass++;
                    n_checks++; if (w_o !== q_w[0]) $display("FAIL b2b_w #%0d: got %h, expected %h", got, w_o, q_w[0]); else n_pass++;
                    n_checks++; if (tag_o !== q_t[0]) $display("FAIL b2b_tag #%0d: got %h, expected %h", got, tag_o, q_t[0]); else n_pass++;
                    void'(q_x.pop_front()); void'(q_w.pop_front()); void'(q_t.pop_front());
                end
            end
        end
        valid_i = 1'b0;
        n_checks++; if (got != 100) $display("FAIL b2b_count: got %0d, expected 100", got); else n_pass++;
        n_checks++; if (last_out - first_in != 99 + PD) $display("FAIL b2b_span: got %0d, expected %0d", last_out - first_in, 99 + PD); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== 16'd100) $display("FAIL b2b_cnt: got %0d, expected 100", cnt_o); else n_pass++;
    endtask

    task automatic test_random_stall();
        int sent, got;
        logic prev_hold;
        logic [XW-1:0] px, ex;
        logic [WW-1:0] pw;
        logic [TAG_W-1:0] pt;
        do_reset();
        q_x.delete(); q_w.delete(); q_t.delete();
        sent = 0; got = 0; prev_hold = 1'b0;
        px = '0; pw = '0; pt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk_i); #1;
            if (cyc < 300) begin
                ready_i = 1'($urandom_range(0, 1));
                valid_i = 1'($urandom_range(0, 1));
                drive_random();
            end else begin
                ready_i = 1'b1;
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            n_checks++; if (ready_o !== (ready_i | ~valid_o)) $display("FAIL stall_ready cyc%0d: got %b, expected %b", cyc, ready_o, ready_i | ~valid_o); else n_pass++;
            if (prev_hold) begin
                n_checks++; if (valid_o !== 1'b1) $display("FAIL stall_hold_valid cyc%0d: got %b, expected 1", cyc, valid_o); else n_pass++;
                n_checks++; if (x_o !== px || w_o !== pw || tag_o !== pt) $display("FAIL stall_hold_data cyc%0d: got %h, expected %h", cyc, x_o, px); else n_pass++;
            end
            if (valid_i && ready_o) begin
                ex = model_all();
                q_x.push_back(ex); q_w.push_back(w_i); q_t.push_back(tag_i);
                sent++;
            end
            if (valid_o && ready_i) begin
                got++;
                n_checks++;
                if (q_x.size() == 0) begin
                    $display("FAIL stall_unexpected: got an output, expected none pending");
                end else begin
                    n_pass++;
                    n_checks++; if (x_o !== q_x[0]) $display("FAIL stall_x #%0d: got %h, expected %h", got, x_o, q_x[0]); else n_pass++;
                    n_checks++; if (w_o !== q_w[0] || tag_o !== q_t[0]) $display("FAIL stall_w_tag #%0d: got %h/%h, expected %h/%h", got, w_o, tag_o, q_w[0], q_t[0]); else n_pass++;
                    void'(q_x.pop_front()); void'(q_w.pop_front()); void'(q_t.pop_front());
                end
            end
            prev_hold = valid_o && !ready_i;
            px = x_o; pw = w_o; pt = tag_o;
        end
        n_checks++; if (sent == 0) $display("FAIL stall_sent: got 0, expected nonzero"); else n_pass++;
        n_checks++; if (got != sent) $display("FAIL stall_loss: got %0d outputs, expected %0d", got, sent); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== CNT_W'(got)) $display("FAIL stall_cnt: got %0d, expected %0d", cnt_o, got); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int lat; logic [XW-1:0] xo; logic [WW-1:0] wo; logic [TAG_W-1:0] to;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        for (int i = 0; i < PD; i++) begin
            valid_i = 1'b1;
            drive_random();
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL mid_full: got %b, expected 1", valid_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b0) $display("FAIL mid_stalled: got %b, expected 0", ready_o); else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b, expected 0", valid_o); else n_pass++;
        n_checks++; if (cnt_o !== '0) $display("FAIL mid_rst_cnt: got %0d, expected 0", cnt_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL mid_rst_ready: got %b, expected 1", ready_o); else n_pass++;
        @(posedge clk_i); #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < PD + 4; i++) begin
            @(posedge clk_i); #1;
            n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_stale cyc%0d: got %b, expected 0", i, valid_o); else n_pass++;
        end
        send_one(2'd0, 64'd5, 64'd7, 64'd11, 8'h77, lat, xo, wo, to);
        n_checks++; if (lat != PD) $display("FAIL mid_latency: got %0d, expected %0d", lat, PD); else n_pass++;
        n_checks++; if (xo[63:0] !== 64'd82) $display("FAIL mid_x: got %h, expected 52", xo[63:0]); else n_pass++;
        n_checks++; if (xo[127:64] !== 64'hFFFF_FFFE_FFFF_FFB9) $display("FAIL mid_y: got %h, expected fffffffeffffffb9", xo[127:64]); else n_pass++;
        n_checks++; if (to !== 8'h77) $display("FAIL mid_tag: got %h, expected 77", to); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (cnt_o !== 16'd1) $display("FAIL mid_cnt: got %0d, expected 1", cnt_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_wrap();
        test_back_to_back();
        test_random_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_butterfly_array.md
Name: ntt_butterfly_array

Overview:
- LANES parallel radix-2 butterflies over the Goldilocks field, p = 2^64 - 2^32 + 1 = 0xFFFFFFFF00000001.
- Unlike a free-running butterfly stage, it has a valid/ready handshake with full-pipeline stall, a per-transaction mode (Cooley-Tukey, Gentleman-Sande, bypass), a tag sideband, twiddle forwarding and an output transaction counter.
- Sits between the NTT reorder buffers and the next butterfly level.

Parameters:
- LANES, 4, number of independent butterflies per transaction (1..16).
- PD, 6, pipeline depth in cycles, input handshake to valid_o (min 3).
- TAG_W, 8, width of the opaque sideband tag.
- CNT_W, 16, width of the output transaction counter.
- CANONICAL, 1, 1: outputs fully reduced to [0,p); 0: outputs may lie in [0,2^64) and be congruent mod p.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  input transaction valid
- ready_o  out  1  block accepts input this cycle
- mode_i  in  2  0=CT, 1=GS, 2=BYPASS, 3=reserved (treated as BYPASS)
- tag_i  in  TAG_W  sideband, returned unchanged with the result
- x_i  in  LANES*2*64  per lane {y,x}; lane k at bits [128k+127:128k], x in the low half
- w_i  in  LANES*64  per-lane twiddle
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts output
- x_o  out  LANES*2*64  results, same packing as x_i
- w_o  out  LANES*64  twiddle delayed alongside its data
- tag_o  out  TAG_W  delayed tag
- cnt_o  out  CNT_W  number of output handshakes since reset

Behaviour:
- Reset (async, rst_ni low): valid_o=0, cnt_o=0, x_o=0, w_o=0, tag_o=0. All pipeline valid bits clear. Reset mid-operation discards all in-flight transactions. ready_o=1 during and after reset.
- Pipeline enable: ce = ready_i | ~valid_o. ready_o = ce, combinational.
- Input handshake: valid_i & ready_o.
- Output handshake: valid_o & ready_i.
- When ce=0, every pipeline stage holds, including data, twiddle, tag, mode and valid.
- Latency: exactly PD enabled cycles from input handshake to valid_o.
- Throughput: one transaction per cycle while ready_i=1. No bubbles are inserted. Order is preserved.
- Bubbles (valid_i=0 while ce=1) propagate as invalid slots. A valid_o=0 slot never blocks the pipe.
- Valid bits:
  - An invalid slot's data is don't-care, except that the x_o/w_o/tag_o registers update only when ce=1.
  - valid_o may rise while ready_i=0. It then holds with stable x_o, w_o and tag_o until the output handshake.
- Arithmetic, per lane, all mod p. Inputs are any 64-bit values; values >= p are treated as v-p.
  - CT: x' = x + w*y, y' = x - w*y.
  - GS: x' = x + y, y' = (x - y)*w.
  - BYPASS: x' = x, y' = y, reduced if CANONICAL=1; w unused.
  - Multiply: full 128-bit product, then Goldilocks reduction using 2^64 ≡ 2^32-1 and 2^96 ≡ -1. Add/sub use a conditional ±p correction.
  - Mode travels with the data. Mixing modes in consecutive cycles is legal.
- CANONICAL=1: every output word < p. CANONICAL=0: output ≡ exact result mod p.
- w_o is w_i of the same transaction, unchanged, in all modes.
- tag_o is tag_i of the same transaction.
- cnt_o increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output handshake in the same cycle is the normal streaming case. No occupancy limit beyond the PD stages is needed, because stall is global.

Test Plan:
1. Reset, then one CT transaction: lane0 x=1, y=2, w=3 -> after PD cycles x'=7, y'=0xFFFFFFFEFFFFFFFC (p-5); w_o=3; tag echoed; cnt_o=1.
2. GS, x=1, y=2, w=3 -> x'=3, y'=0xFFFFFFFEFFFFFFFE (p-3).
3. Wrap boundary, CT, x=p-1, y=1, w=1 -> x'=0, y'=0xFFFFFFFEFFFFFFFF (p-2). Also BYPASS with x=0xFFFFFFFFFFFFFFFF, CANONICAL=1 -> x'=0x00000000FFFFFFFE.
4. Back-to-back stream of 100 random mixed-mode transactions, ready_i=1 -> zero bubbles; outputs match the reference model in order; cnt_o=100.
5. Random ready_i toggling (50%), random valid_i -> no loss or duplication. Outputs stay stable while valid_o=1 & ready_i=0. ready_o equals ready_i | ~valid_o every cycle.
6. Assert rst_ni for 1 cycle with PD transactions in flight -> valid_o=0 and cnt_o=0 immediately. No stale output after release. A new transaction completes with correct latency.
